// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T-FF counter controller.
//   tff_state_e : controller FSM states
//   DIR_UP/DIR_DOWN : encodings of the dir input / captured direction
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tff_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH rising-edge T flip-flops with asynchronous active-low clear.
//   clk  : clock
//   rst  : async active-low reset, clears every bit to 0
//   t    : per-bit toggle enable, q[i] flips on the edge when t[i] = 1
//   q    : stored bits
//   qbar : complement of q
module tff_bank #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller that drives the toggle inputs of a T-FF bank so the
// bank acts as a loadable up/down counter running to a programmed limit.
//   clk      : clock, rising edge
//   rst      : async active-low reset
//   load     : load request (IDLE only), load_val appears on q after one edge
//   load_val : value to load
//   start    : start a counting job (IDLE only), dir/limit captured here
//   dir      : 1 = count up, 0 = count down
//   limit    : terminal value
//   stop     : abort a running job (RUN only), q holds, no done
//   q        : current bank contents
//   busy     : high while counting
//   done     : one-cycle pulse after the limit is reached
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    tff_state_e       state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] down_mask;

    // Ripple-carry / ripple-borrow toggle masks: bit i flips when all lower
    // bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        up_mask      = '0;
        down_mask    = '0;
        up_mask[0]   = 1'b1;
        down_mask[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            up_mask[i]   = up_mask[i-1] & q[i-1];
            down_mask[i] = down_mask[i-1] & qbar[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        t       = '0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    // Toggling exactly the differing bits lands q on load_val.
                    t = q ^ load_val;
                end else if (start) begin
                    dir_d   = dir;
                    limit_d = limit;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (q == limit_q) begin
                    state_d = DONE;
                end else begin
                    t = (dir_q == DIR_UP) ? up_mask : down_mask;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .q    (q),
        .qbar (qbar)
    );

endmodule

// File: tb/tb_tff_count_ctrl.sv
module tb_tff_count_ctrl;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    tff_count_ctrl #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .dir      (dir),
        .limit    (limit),
        .stop     (stop),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs after each rising edge against the
    // oldest expectation issued by the stimulus process.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q", q, e.q);
                check("busy", {3'b0, busy}, {3'b0, e.busy});
                check("done", {3'b0, done}, {3'b0, e.done});
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic cyc(input logic ld, input logic [WIDTH-1:0] lv, input logic st,
                       input logic d, input logic [WIDTH-1:0] lim, input logic sp,
                       input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        load     = ld;
        load_val = lv;
        start    = st;
        dir      = d;
        limit    = lim;
        stop     = sp;
        e.q      = eq;
        e.busy   = eb;
        e.done   = ed;
        sb.push_back(e);
    endtask

    // Idle cycle with only an expectation.
    task automatic idle(input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, eq, eb, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        dir = 1'b0; limit = '0; stop = 1'b0;
        #12;
        check("reset_q", q, 4'h0);
        check("reset_busy", {3'b0, busy}, 4'h0);
        check("reset_done", {3'b0, done}, 4'h0);
        @(negedge clk);
        rst = 1'b1;

        // Loads, and load winning over a simultaneous start.
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b1, 1'b1, 4'hC, 1'b0, 4'hA, 1'b0, 1'b0);
        idle(4'hA, 1'b0, 1'b0);
        // stop in IDLE is ignored.
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 1'b0);

        // Up 3 -> 7; load/start/dir/limit changes during RUN are ignored.
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0, 4'h3, 1'b1, 1'b0);
        cyc(1'b1, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 4'h4, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 4'h5, 1'b1, 1'b0);
        idle(4'h6, 1'b1, 1'b0);
        idle(4'h7, 1'b1, 1'b0);
        idle(4'h7, 1'b0, 1'b1);
        idle(4'h7, 1'b0, 1'b0);

        // Down 2 -> E with wrap through 0.
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 1'b0, 4'h2, 1'b1, 1'b0);
        idle(4'h1, 1'b1, 1'b0);
        idle(4'h0, 1'b1, 1'b0);
        idle(4'hF, 1'b1, 1'b0);
        idle(4'hE, 1'b1, 1'b0);
        idle(4'hE, 1'b0, 1'b1);
        idle(4'hE, 1'b0, 1'b0);

        // Start with q already at the limit.
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h6, 1'b1, 1'b0);
        idle(4'h6, 1'b0, 1'b1);
        idle(4'h6, 1'b0, 1'b0);

        // Up wrap F -> 0 -> 1.
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0);
        idle(4'h0, 1'b1, 1'b0);
        idle(4'h1, 1'b1, 1'b0);
        idle(4'h1, 1'b0, 1'b1);
        idle(4'h1, 1'b0, 1'b0);

        // Abort at q=4 while counting 0 -> 9, then a fresh job to 5.
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0);
        idle(4'h1, 1'b1, 1'b0);
        idle(4'h2, 1'b1, 1'b0);
        idle(4'h3, 1'b1, 1'b0);
        idle(4'h4, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0);
        idle(4'h4, 1'b0, 1'b0);
        idle(4'h4, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 1'b0, 4'h4, 1'b1, 1'b0);
        idle(4'h5, 1'b1, 1'b0);
        idle(4'h5, 1'b0, 1'b1);
        idle(4'h5, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an up count at q=5.
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 1'b0);
        idle(4'h5, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_q", q, 4'h0);
        check("async_rst_busy", {3'b0, busy}, 4'h0);
        check("async_rst_done", {3'b0, done}, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1, 1'b0);
        idle(4'h1, 1'b1, 1'b0);
        idle(4'h2, 1'b1, 1'b0);
        idle(4'h2, 1'b0, 1'b1);
        idle(4'h2, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size() == 0 ? 4'h0 : 4'h1, 4'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
